// File: rtl/logic_proc_pkg.sv
// Shared types for the bit-serial logic processor: function codes, routing
// codes and the control FSM state encoding.
package logic_proc_pkg;

  typedef enum logic [2:0] {
    FUNC_AND  = 3'b000,
    FUNC_OR   = 3'b001,
    FUNC_XOR  = 3'b010,
    FUNC_ONE  = 3'b011,
    FUNC_ANDN = 3'b100,
    FUNC_ORN  = 3'b101,
    FUNC_XNOR = 3'b110,
    FUNC_ZERO = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    ROUTE_KEEP = 2'b00,
    ROUTE_B_F  = 2'b01,
    ROUTE_A_F  = 2'b10,
    ROUTE_SWAP = 2'b11
  } route_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_func_cell.sv
// One-bit combinational function unit applied to the serial operand bits.
module serial_func_cell
  import logic_proc_pkg::*;
(
  input  func_e func,
  input  logic  a,
  input  logic  b,
  output logic  f
);

  always_comb begin
    f = 1'b0;
    case (func)
      FUNC_AND:  f = a & b;
      FUNC_OR:   f = a | b;
      FUNC_XOR:  f = a ^ b;
      FUNC_ONE:  f = 1'b1;
      FUNC_ANDN: f = a & ~b;
      FUNC_ORN:  f = a | ~b;
      FUNC_XNOR: f = ~(a ^ b);
      FUNC_ZERO: f = 1'b0;
      default:   f = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic_processor.sv
// Bit-serial logic processor: two WIDTH-bit operand registers shifted right
// through a one-bit function cell, with results routed back into A and/or B.
//
// state | meaning
// IDLE  | loads honoured; Start latches F/R and begins an operation
// SHIFT | one shift per cycle, WIDTH cycles total
// DONE  | result held until Start is released (no re-trigger)
module serial_logic_processor
  import logic_proc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Start,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  output logic [WIDTH-1:0] A_val,
  output logic [WIDTH-1:0] B_val,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  func_e            fq;
  route_e           rq;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, a_next, b_next;
  logic             bit_a, bit_b, bit_f, ain, bin, last_shift;

  assign bit_a      = a_q[0];
  assign bit_b      = b_q[0];
  assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

  serial_func_cell u_func (
    .func (fq),
    .a    (bit_a),
    .b    (bit_b),
    .f    (bit_f)
  );

  always_comb begin
    ain = bit_a;
    bin = bit_b;
    case (rq)
      ROUTE_KEEP: begin ain = bit_a; bin = bit_b; end
      ROUTE_B_F:  begin ain = bit_a; bin = bit_f; end
      ROUTE_A_F:  begin ain = bit_f; bin = bit_b; end
      ROUTE_SWAP: begin ain = bit_b; bin = bit_a; end
      default:    begin ain = bit_a; bin = bit_b; end
    endcase
  end

  // Written as shift-then-insert so WIDTH=1 needs no special slice.
  always_comb begin
    a_next            = a_q >> 1;
    b_next            = b_q >> 1;
    a_next[WIDTH-1]   = ain;
    b_next[WIDTH-1]   = bin;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (!Start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == SHIFT);
    Done = (state_q == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      fq    <= FUNC_AND;
      rq    <= ROUTE_KEEP;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (LoadA) a_q <= Din;
          if (LoadB) b_q <= Din;
          if (Start) begin
            fq    <= func_e'(F);
            rq    <= route_e'(R);
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          a_q   <= a_next;
          b_q   <= b_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign A_val = a_q;
  assign B_val = b_q;

endmodule

// File: tb/tb_serial_logic_processor.sv
// Directed bench for serial_logic_processor at WIDTH=8 and WIDTH=1.
module tb_serial_logic_processor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       LoadA = 1'b0, LoadB = 1'b0, Start = 1'b0;
  logic [7:0] Din = '0;
  logic [2:0] F = '0;
  logic [1:0] R = '0;
  logic [7:0] A_val, B_val;
  logic       Busy, Done;

  logic       w1_LoadA = 1'b0, w1_LoadB = 1'b0, w1_Start = 1'b0;
  logic [0:0] w1_Din = '0;
  logic [2:0] w1_F = '0;
  logic [1:0] w1_R = '0;
  logic [0:0] w1_A_val, w1_B_val;
  logic       w1_Busy, w1_Done;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  serial_logic_processor #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Start(Start),
    .Din(Din), .F(F), .R(R), .A_val(A_val), .B_val(B_val), .Busy(Busy), .Done(Done)
  );

  serial_logic_processor #(.WIDTH(1)) dut_w1 (
    .Clk(Clk), .Reset(Reset), .LoadA(w1_LoadA), .LoadB(w1_LoadB), .Start(w1_Start),
    .Din(w1_Din), .F(w1_F), .R(w1_R), .A_val(w1_A_val), .B_val(w1_B_val),
    .Busy(w1_Busy), .Done(w1_Done)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    LoadA = 1'b1; Din = a; step();
    LoadA = 1'b0; LoadB = 1'b1; Din = b; step();
    LoadB = 1'b0;
  endtask

  // Start is already high and the accepting edge has passed; count Busy cycles.
  task automatic wait_busy(output int n);
    n = 0;
    for (int i = 0; i < 40 && Busy; i++) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; step(); Reset = 1'b0;
    checks++; if (A_val !== 8'h00) begin errors++; $display("FAIL reset_a: got %h want 00", A_val); end
    checks++; if (B_val !== 8'h00) begin errors++; $display("FAIL reset_b: got %h want 00", B_val); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
  endtask

  task automatic test_xor_to_a();
    int n;
    load_ab(8'hF0, 8'hCC);
    F = 3'b010; R = 2'b10; Start = 1'b1; step();
    wait_busy(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL xor_busy_cycles: got %0d want 8", n); end
    checks++; if (A_val !== 8'h3C) begin errors++; $display("FAIL xor_a: got %h want 3c", A_val); end
    checks++; if (B_val !== 8'hCC) begin errors++; $display("FAIL xor_b: got %h want cc", B_val); end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL xor_done: got %b want 1", Done); end
    Start = 1'b0; step();
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL xor_release: got done=%b busy=%b want 0 0", Done, Busy); end
  endtask

  task automatic test_ignore_during_shift();
    int n;
    load_ab(8'hA5, 8'h0F);
    F = 3'b000; R = 2'b01; Start = 1'b1; step();
    F = 3'b111; LoadA = 1'b1; Din = 8'hFF; step();
    wait_busy(n);
    LoadA = 1'b0;
    checks++; if (n !== 7) begin errors++; $display("FAIL and_busy_cycles: got %0d want 7", n); end
    checks++; if (B_val !== 8'h05) begin errors++; $display("FAIL and_b: got %h want 05", B_val); end
    checks++; if (A_val !== 8'hA5) begin errors++; $display("FAIL and_a: got %h want a5", A_val); end
    Start = 1'b0; step();
  endtask

  task automatic test_swap_keep();
    int n;
    load_ab(8'h12, 8'h34);
    F = 3'b011; R = 2'b11; Start = 1'b1; step();
    wait_busy(n);
    checks++; if (A_val !== 8'h34) begin errors++; $display("FAIL swap_a: got %h want 34", A_val); end
    checks++; if (B_val !== 8'h12) begin errors++; $display("FAIL swap_b: got %h want 12", B_val); end
    Start = 1'b0; step();
    F = 3'b111; R = 2'b00; Start = 1'b1; step();
    wait_busy(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL keep_busy_cycles: got %0d want 8", n); end
    checks++; if (A_val !== 8'h34 || B_val !== 8'h12) begin errors++; $display("FAIL keep_ab: got %h %h want 34 12", A_val, B_val); end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL keep_done: got %b want 1", Done); end
    Start = 1'b0; step();
  endtask

  task automatic test_back_to_back_hold();
    int total = 0;
    load_ab(8'h0F, 8'h01);
    F = 3'b001; R = 2'b01; Start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (Busy) total++;
    end
    checks++; if (total !== 8) begin errors++; $display("FAIL hold_busy_cycles: got %0d want 8", total); end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b want 1", Done); end
    checks++; if (B_val !== 8'h0F) begin errors++; $display("FAIL hold_b: got %h want 0f", B_val); end
    Start = 1'b0; step();
  endtask

  task automatic test_reset_mid_op();
    load_ab(8'h5A, 8'hC3);
    F = 3'b010; R = 2'b10; Start = 1'b1; step();
    for (int i = 0; i < 4; i++) step();
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", Busy); end
    Reset = 1'b1; step(); Reset = 1'b0; Start = 1'b0;
    checks++; if (A_val !== 8'h00 || B_val !== 8'h00) begin errors++; $display("FAIL abort_ab: got %h %h want 00 00", A_val, B_val); end
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL abort_flags: got busy=%b done=%b want 0 0", Busy, Done); end
    step();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b want 0", Busy); end
  endtask

  task automatic test_width1();
    int n;
    w1_LoadA = 1'b1; w1_Din = 1'b1; step();
    w1_LoadA = 1'b0; w1_LoadB = 1'b1; w1_Din = 1'b0; step(); w1_LoadB = 1'b0;
    w1_F = 3'b101; w1_R = 2'b10; w1_Start = 1'b1; step();
    n = 0;
    for (int i = 0; i < 10 && w1_Busy; i++) begin n++; step(); end
    checks++; if (n !== 1) begin errors++; $display("FAIL w1_busy_cycles: got %0d want 1", n); end
    checks++; if (w1_A_val !== 1'b1 || w1_Done !== 1'b1) begin errors++; $display("FAIL w1_orn: got a=%b done=%b want 1 1", w1_A_val, w1_Done); end
    w1_Start = 1'b0; step();
    w1_LoadB = 1'b1; w1_Din = 1'b1; step(); w1_LoadB = 1'b0;
    w1_Din = 1'b1; w1_LoadA = 1'b1; w1_F = 3'b100; w1_R = 2'b10; w1_Start = 1'b1; step();
    w1_LoadA = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && w1_Busy; i++) begin n++; step(); end
    checks++; if (w1_A_val !== 1'b0 || w1_B_val !== 1'b1) begin errors++; $display("FAIL w1_andn: got a=%b b=%b want 0 1", w1_A_val, w1_B_val); end
    w1_Start = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_xor_to_a();
    test_ignore_during_shift();
    test_swap_keep();
    test_back_to_back_hold();
    test_reset_mid_op();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
